integral_rect_responder: RTL
============================

// Module: integral_rect_responder
// PURPOSE
//  Responder side of the integral-image rectangle-sum query interface driven by the feature calculator.
//  Accepts (x1,y1)-(x2,y2) inclusive corner queries and reads four corners from integral-image RAM.
//  Returns sum = D - B - C + A, where A=II(x1-1,y1-1), B=II(x2,y1-1), C=II(x1-1,y2), D=II(x2,y2).
//  Sits between the feature calculator and the integral-image RAM that the integral-image builder writes.
// PARAMETERS
//  IMG_W       320  image width in pixels (row pitch of II RAM)
//  IMG_H       240  image height in pixels
//  SUM_WIDTH   24   II word width = rect_sum width; all arithmetic is modulo 2^SUM_WIDTH
//  ADDR_WIDTH  17   II RAM address width; must satisfy IMG_W*IMG_H <= 2^ADDR_WIDTH
// PORTS
//  clk           in   1           single clock, rising edge
//  rst_n         in   1           reset, asynchronous, active-low
//  query_x1      in   16          left column, inclusive
//  query_y1      in   16          top row, inclusive
//  query_x2      in   16          right column, inclusive
//  query_y2      in   16          bottom row, inclusive
//  query_valid   in   1           request; held high by initiator until rect_sum_valid seen
//  rect_sum      out  SUM_WIDTH   rectangle sum; valid only while rect_sum_valid=1
//  rect_sum_valid out 1           one-cycle response pulse
//  query_err     out  1           pulses with rect_sum_valid when the query was rejected
//  busy          out  1           high in every state except IDLE
//  ii_rd_en      out  1           II RAM read enable (registered)
//  ii_rd_addr    out  ADDR_WIDTH  II RAM address = y*IMG_W + x (registered)
//  ii_rd_data    in   SUM_WIDTH   II RAM data, 1-cycle synchronous read latency
//  query_count   out  16          accepted queries (QUERY_STATS_EN only)
//  err_count     out  16          rejected queries (QUERY_STATS_EN only)
// BEHAVIOUR
//  - Clocking: one clock; reset is asynchronous and active-low.
//  - Reset values: every output 0; state=IDLE; armed=1.
//  - FSM states: IDLE, CHECK, READ (corner slots 0..3 = A,B,C,D), DRAIN, CALC, RESP, REARM.
//  - IDLE: if query_valid && armed, latch all four coordinates and go to CHECK.
//  - Coordinates are sampled only at acceptance; later changes are ignored.
//  - CHECK: query is rejected if x1>x2, y1>y2, x2>=IMG_W or y2>=IMG_H.
//    This catches the 0xFFFF underflow that a zero-width/zero-height rectangle produces.
//  - Rejected query: go to RESP with rect_sum=0 and query_err=1.
//  - Valid query: go to READ.
//  - READ: one corner per cycle, in order A,B,C,D.
//    A and B are skipped when y1==0; A and C are skipped when x1==0.
//    A skipped corner keeps its slot (ii_rd_en=0) and contributes 0, so latency is constant.
//  - DRAIN: captures the D data. CALC: sum = D - B - C + A, wrapping in SUM_WIDTH bits.
//  - Latency from the accept edge to rect_sum_valid high: 7 cycles for a valid query, 2 for a rejected one.
//  - RESP: drive rect_sum_valid=1 (and query_err if rejected) for exactly one cycle, then go to REARM.
//  - REARM: wait for query_valid==0, then go to IDLE.
//    This prevents a double response while the initiator's query_valid falls.
//  - Queries arriving while busy are not accepted. No queueing; depth is one.
//  - Reset mid-query: immediate abort, no response issued.
//    A query_valid still high after reset release is accepted as new.
// CONFIGURATION
//  - QUERY_STATS_EN defined: two 16-bit saturating counters.
//    query_count increments on every accept; err_count increments on every reject.
//    Both counters clear only on reset.
//  - QUERY_STATS_EN undefined: query_count and err_count are tied to 0 and no counter flops exist.
// STRUCTURE
//  - face_det_pkg: IMG_W/IMG_H defaults, SUM_WIDTH, FSM state encoding, corner slot indices A/B/C/D.
//  - Sub-module ii_corner_addr: combinational (x,y,slot) -> {addr, skip}.
//    Uses the IMG_W constant multiply; x-1 and y-1 handling lives here.
// TESTING
//  1. Fill II RAM from a 320x240 image of all 1s, query (10,20)-(19,29).
//     Expect rect_sum=100 at 7 cycles, query_err=0.
//  2. Edge query (0,0)-(3,3) on the same image: expect 16.
//     Exactly one ii_rd_en pulse occurs (D only).
//  3. Degenerate query x1=5, x2=0xFFFF: expect rect_sum=0 and query_err=1 at 2 cycles, no RAM reads.
//  4. II words preloaded near 2^24 wrap (D=0x000010, B=0xFFFFF0, C=0, A=0): expect 0x000020.
//  5. Hold query_valid high 3 cycles after the response: exactly one rect_sum_valid pulse.
//     A new query is accepted only after query_valid drops.
//  6. Assert rst_n low during READ: outputs return to 0, no response pulse.
//     With QUERY_STATS_EN, 3 good + 1 bad query give query_count=4 and err_count=1.

Source files
------------

// File: rtl/face_det_pkg.sv
// rtl/face_det_pkg.sv - shared constants, FSM encoding and corner slots for the integral-image rectangle responder
package face_det_pkg;

  localparam int IMG_W_DEF      = 320;
  localparam int IMG_H_DEF      = 240;
  localparam int SUM_WIDTH_DEF  = 24;
  localparam int ADDR_WIDTH_DEF = 17;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CALC  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;
  localparam logic [2:0] ST_REARM = 3'd6;

  // Read order is fixed A, B, C, D so every query has the same latency.
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  typedef struct packed {
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] x2;
    logic [15:0] y2;
  } rect_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ii_corner_addr.sv
// rtl/ii_corner_addr.sv - maps a query rectangle and corner slot to an II RAM address and a skip flag
module ii_corner_addr
  import face_det_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  rect_t                 rect,
  input  logic [1:0]            slot,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  skip
);

  logic [15:0] col;
  logic [15:0] row;

  // Corners left of column 0 or above row 0 read as zero; their underflowed
  // coordinates still produce an address, but the skip flag suppresses the read.
  always_comb begin
    col  = rect.x2;
    row  = rect.y2;
    skip = 1'b0;
    case (slot)
      SLOT_A: begin
        col  = rect.x1 - 16'd1;
        row  = rect.y1 - 16'd1;
        skip = (rect.x1 == 16'd0) || (rect.y1 == 16'd0);
      end
      SLOT_B: begin
        col  = rect.x2;
        row  = rect.y1 - 16'd1;
        skip = (rect.y1 == 16'd0);
      end
      SLOT_C: begin
        col  = rect.x1 - 16'd1;
        row  = rect.y2;
        skip = (rect.x1 == 16'd0);
      end
      default: begin
        col  = rect.x2;
        row  = rect.y2;
        skip = 1'b0;
      end
    endcase
  end

  assign addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(col);

endmodule

// File: rtl/integral_rect_responder.sv
// rtl/integral_rect_responder.sv - rectangle-sum responder over integral-image RAM; QUERY_STATS_EN adds query/error counters
module integral_rect_responder
  import face_det_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int SUM_WIDTH  = SUM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           query_x1,
  input  logic [15:0]           query_y1,
  input  logic [15:0]           query_x2,
  input  logic [15:0]           query_y2,
  input  logic                  query_valid,
  output logic [SUM_WIDTH-1:0]  rect_sum,
  output logic                  rect_sum_valid,
  output logic                  query_err,
  output logic                  busy,
  output logic                  ii_rd_en,
  output logic [ADDR_WIDTH-1:0] ii_rd_addr,
  input  logic [SUM_WIDTH-1:0]  ii_rd_data,
  output logic [15:0]           query_count,
  output logic [15:0]           err_count
);

  localparam logic [15:0] W_LIM = 16'(IMG_W);
  localparam logic [15:0] H_LIM = 16'(IMG_H);

  logic [2:0]           state;
  logic [1:0]           slot;
  logic                 armed;
  logic                 err_q;
  rect_t                rect;
  logic [SUM_WIDTH-1:0] corner_a;
  logic [SUM_WIDTH-1:0] corner_b;
  logic [SUM_WIDTH-1:0] corner_c;
  logic [SUM_WIDTH-1:0] corner_d;
  logic                 pend_valid;
  logic [1:0]           pend_slot;

  logic                  accept;
  logic                  rect_bad;
  logic                  reject;
  logic [1:0]            next_slot;
  logic [ADDR_WIDTH-1:0] corner_addr;
  logic                  corner_skip;
  logic [SUM_WIDTH-1:0]  sum_calc;

  assign accept    = (state == ST_IDLE) && query_valid && armed;
  assign rect_bad  = (rect.x1 > rect.x2) || (rect.y1 > rect.y2) ||
                     (rect.x2 >= W_LIM) || (rect.y2 >= H_LIM);
  assign reject    = (state == ST_CHECK) && rect_bad;
  assign next_slot = (state == ST_CHECK) ? SLOT_A : slot + 2'd1;
  assign sum_calc  = corner_d - corner_b - corner_c + corner_a;
  assign busy      = (state != ST_IDLE);

  ii_corner_addr #(
    .IMG_W      (IMG_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_corner_addr (
    .rect (rect),
    .slot (next_slot),
    .addr (corner_addr),
    .skip (corner_skip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      slot           <= SLOT_A;
      armed          <= 1'b1;
      err_q          <= 1'b0;
      rect           <= '0;
      corner_a       <= '0;
      corner_b       <= '0;
      corner_c       <= '0;
      corner_d       <= '0;
      pend_valid     <= 1'b0;
      pend_slot      <= SLOT_A;
      rect_sum       <= '0;
      rect_sum_valid <= 1'b0;
      query_err      <= 1'b0;
      ii_rd_en       <= 1'b0;
      ii_rd_addr     <= '0;
    end else begin
      // RAM data lags the read strobe by one cycle; remember which corner it belongs to.
      pend_valid     <= ii_rd_en;
      pend_slot      <= slot;
      rect_sum_valid <= 1'b0;
      query_err      <= 1'b0;

      if (pend_valid) begin
        case (pend_slot)
          SLOT_A:  corner_a <= ii_rd_data;
          SLOT_B:  corner_b <= ii_rd_data;
          SLOT_C:  corner_c <= ii_rd_data;
          default: corner_d <= ii_rd_data;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            rect     <= '{x1: query_x1, y1: query_y1, x2: query_x2, y2: query_y2};
            armed    <= 1'b0;
            corner_a <= '0;
            corner_b <= '0;
            corner_c <= '0;
            corner_d <= '0;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Rejects detour through CALC so both paths share the response register.
          if (rect_bad) begin
            err_q <= 1'b1;
            state <= ST_CALC;
          end else begin
            err_q      <= 1'b0;
            slot       <= next_slot;
            ii_rd_en   <= ~corner_skip;
            ii_rd_addr <= corner_skip ? '0 : corner_addr;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          if (slot == SLOT_D) begin
            ii_rd_en   <= 1'b0;
            ii_rd_addr <= '0;
            state      <= ST_DRAIN;
          end else begin
            slot       <= next_slot;
            ii_rd_en   <= ~corner_skip;
            ii_rd_addr <= corner_skip ? '0 : corner_addr;
          end
        end
        ST_DRAIN: begin
          state <= ST_CALC;
        end
        ST_CALC: begin
          rect_sum       <= err_q ? '0 : sum_calc;
          rect_sum_valid <= 1'b1;
          query_err      <= err_q;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          rect_sum <= '0;
          state    <= ST_REARM;
        end
        ST_REARM: begin
          if (!query_valid) begin
            armed <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef QUERY_STATS_EN
  logic [15:0] q_cnt;
  logic [15:0] e_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt <= '0;
      e_cnt <= '0;
    end else begin
      if (accept) q_cnt <= sat_inc16(q_cnt);
      if (reject) e_cnt <= sat_inc16(e_cnt);
    end
  end

  assign query_count = q_cnt;
  assign err_count   = e_cnt;
`else
  assign query_count = '0;
  assign err_count   = '0;
`endif

endmodule
